// File: rtl/multicycle_sequencer.sv
// Multicycle control sequencer for the LEGv8 datapath.
// Steps each instruction through FETCH, DECODE, EXECUTE and, for loads and
// stores, MEM. It owns the RAM handshake and the shared address-bus select,
// and it gates the decoder's WR/SFL strobes so each fires once per instruction.
// Strobes are combinational in the current state and inputs. State, the RAM
// wait counter, the retired count and the fault flag are registered.
module multicycle_sequencer #(
    parameter int MEM_WAIT_MAX = 15,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             Reset,
    input  logic             dec_WR,
    input  logic             dec_SFL,
    input  logic             dec_load,
    input  logic             dec_store,
    input  logic             dec_branch,
    input  logic             mem_ready,
    input  logic             halt,
    output logic             IL,
    output logic             EN_ADDR_PC,
    output logic             EN_ADDR_ALU,
    output logic             RCS,
    output logic             RR,
    output logic             WRR,
    output logic             WR,
    output logic             SFL,
    output logic             PC_INC,
    output logic             PC_LOAD,
    output logic             busy,
    output logic             fault,
    output logic [2:0]       state,
    output logic [CNT_W-1:0] retired
);

    // Wait counter must be able to hold MEM_WAIT_MAX itself.
    localparam int WAIT_W = (MEM_WAIT_MAX < 1) ? 1 : $clog2(MEM_WAIT_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH   = 3'd0,
        S_DECODE  = 3'd1,
        S_EXECUTE = 3'd2,
        S_MEM     = 3'd3,
        S_HALTED  = 3'd4,
        S_FAULT   = 3'd5
    } state_t;

    state_t             r_state;
    logic [WAIT_W-1:0]  r_wait;
    logic [CNT_W-1:0]   r_retired;
    logic               r_fault;

    logic               w_multi_class;
    logic               w_mem_class;
    logic               w_wait_limit;

    // True when more than one instruction class is flagged at once.
    // The decoder should never do this, so the sequencer treats it as a fault.
    function automatic logic f_multi_class(input logic ld, input logic st, input logic br);
        return (ld & st) | (ld & br) | (st & br);
    endfunction

    assign w_multi_class = f_multi_class(dec_load, dec_store, dec_branch);
    assign w_mem_class   = dec_load | dec_store;
    assign w_wait_limit  = (r_wait == WAIT_W'(MEM_WAIT_MAX));

    // State, wait counter, retired count and sticky fault all advance here.
    // An instruction retires from EXECUTE (ALU op or branch) or from MEM when
    // the RAM finishes. At that point halt chooses HALTED or the next FETCH.
    always_ff @(posedge clk) begin
        if (Reset) begin
            r_state   <= S_FETCH;
            r_wait    <= '0;
            r_retired <= '0;
            r_fault   <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (mem_ready) begin
                        r_state <= S_DECODE;
                        r_wait  <= '0;
                    end else if (w_wait_limit) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                        r_wait  <= '0;
                    end else begin
                        r_wait  <= r_wait + WAIT_W'(1);
                    end
                end
                S_DECODE: begin
                    r_state <= S_EXECUTE;
                end
                S_EXECUTE: begin
                    if (w_multi_class) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                    end else if (!dec_branch && w_mem_class) begin
                        r_state <= S_MEM;
                        r_wait  <= '0;
                    end else begin
                        r_retired <= r_retired + CNT_W'(1);
                        r_wait    <= '0;
                        r_state   <= halt ? S_HALTED : S_FETCH;
                    end
                end
                S_MEM: begin
                    if (mem_ready) begin
                        r_retired <= r_retired + CNT_W'(1);
                        r_wait    <= '0;
                        r_state   <= halt ? S_HALTED : S_FETCH;
                    end else if (w_wait_limit) begin
                        r_state <= S_FAULT;
                        r_fault <= 1'b1;
                        r_wait  <= '0;
                    end else begin
                        r_wait  <= r_wait + WAIT_W'(1);
                    end
                end
                S_HALTED: begin
                    if (!halt) begin
                        r_state <= S_FETCH;
                        r_wait  <= '0;
                    end
                end
                S_FAULT: begin
                    r_state <= S_FAULT;
                end
                default: begin
                    r_state <= S_FAULT;
                    r_fault <= 1'b1;
                end
            endcase
        end
    end

    // Strobes are decoded from the current state and inputs.
    // Reset forces every 1-bit output low, which also drops a pending access.
    always_comb begin
        IL          = 1'b0;
        EN_ADDR_PC  = 1'b0;
        EN_ADDR_ALU = 1'b0;
        RCS         = 1'b0;
        RR          = 1'b0;
        WRR         = 1'b0;
        WR          = 1'b0;
        SFL         = 1'b0;
        PC_INC      = 1'b0;
        PC_LOAD     = 1'b0;
        busy        = 1'b0;
        fault       = 1'b0;
        if (!Reset) begin
            busy  = (r_state != S_HALTED) && (r_state != S_FAULT);
            fault = r_fault;
            case (r_state)
                S_FETCH: begin
                    EN_ADDR_PC = 1'b1;
                    RCS        = 1'b1;
                    RR         = 1'b1;
                    IL         = mem_ready;
                    PC_INC     = mem_ready;
                end
                S_EXECUTE: begin
                    if (!w_multi_class) begin
                        if (dec_branch) begin
                            PC_LOAD = 1'b1;
                        end else if (!w_mem_class) begin
                            WR  = dec_WR;
                            SFL = dec_SFL;
                        end
                    end
                end
                S_MEM: begin
                    EN_ADDR_ALU = 1'b1;
                    RCS         = 1'b1;
                    RR          = dec_load;
                    WRR         = dec_store;
                    WR          = dec_load & mem_ready;
                end
                default: begin
                end
            endcase
        end
    end

    assign state   = Reset ? 3'd0 : r_state;
    assign retired = r_retired;

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench for multicycle_sequencer, built with a 4-bit retired counter
// so that wrap-around is reachable.
// A per-instruction phase model predicts every output on each cycle.
// Literal expectations at key points check the model's own timing.
module tb_multicycle_sequencer;

    localparam int CNT_W = 4;
    localparam int MWM   = 15;

    // Phase codes follow the published state numbering.
    localparam int P_FETCH = 0, P_DECODE = 1, P_EXEC = 2, P_MEM = 3, P_HALT = 4, P_FAULT = 5;

    logic clk = 1'b0;
    logic Reset, dec_WR, dec_SFL, dec_load, dec_store, dec_branch, mem_ready, halt;
    logic IL, EN_ADDR_PC, EN_ADDR_ALU, RCS, RR, WRR, WR, SFL, PC_INC, PC_LOAD, busy, fault;
    logic [2:0]       state;
    logic [CNT_W-1:0] retired;

    int n_checks = 0;
    int n_errors = 0;

    // Model state.
    int m_ph    = P_FETCH;
    int m_stall = 0;
    int m_ret   = 0;

    multicycle_sequencer #(.MEM_WAIT_MAX(MWM), .CNT_W(CNT_W)) dut (
        .clk(clk), .Reset(Reset),
        .dec_WR(dec_WR), .dec_SFL(dec_SFL), .dec_load(dec_load),
        .dec_store(dec_store), .dec_branch(dec_branch),
        .mem_ready(mem_ready), .halt(halt),
        .IL(IL), .EN_ADDR_PC(EN_ADDR_PC), .EN_ADDR_ALU(EN_ADDR_ALU),
        .RCS(RCS), .RR(RR), .WRR(WRR), .WR(WR), .SFL(SFL),
        .PC_INC(PC_INC), .PC_LOAD(PC_LOAD), .busy(busy), .fault(fault),
        .state(state), .retired(retired)
    );

    always #5 clk = ~clk;

    // Bit order: IL, EN_ADDR_PC, EN_ADDR_ALU, RCS, RR, WRR, WR, SFL, PC_INC, PC_LOAD, busy, fault.
    function automatic logic [11:0] dut_vec();
        return {IL, EN_ADDR_PC, EN_ADDR_ALU, RCS, RR, WRR, WR, SFL, PC_INC, PC_LOAD, busy, fault};
    endfunction

    // Expected outputs for the model's current phase and the present inputs.
    function automatic logic [11:0] model_vec();
        logic il, pc, alu, cs, rd, wrr, wr, sfl, inc, ld, bsy, flt;
        int nclass;
        {il, pc, alu, cs, rd, wrr, wr, sfl, inc, ld, bsy, flt} = '0;
        nclass = int'(dec_load) + int'(dec_store) + int'(dec_branch);
        if (!Reset) begin
            bsy = (m_ph != P_HALT) && (m_ph != P_FAULT);
            flt = (m_ph == P_FAULT);
            if (m_ph == P_FETCH) begin
                pc = 1; cs = 1; rd = 1; il = mem_ready; inc = mem_ready;
            end
            if (m_ph == P_EXEC && nclass == 1 && dec_branch) ld = 1;
            if (m_ph == P_EXEC && nclass == 0) begin
                wr = dec_WR; sfl = dec_SFL;
            end
            if (m_ph == P_MEM) begin
                alu = 1; cs = 1; rd = dec_load; wrr = dec_store; wr = dec_load && mem_ready;
            end
        end
        return {il, pc, alu, cs, rd, wrr, wr, sfl, inc, ld, bsy, flt};
    endfunction

    // Advance the model by one clock edge.
    task automatic model_step();
        int nclass;
        bit done;
        nclass = int'(dec_load) + int'(dec_store) + int'(dec_branch);
        done = 0;
        if (Reset) begin
            m_ph = P_FETCH; m_stall = 0; m_ret = 0;
        end else begin
            case (m_ph)
                P_FETCH, P_MEM: begin
                    if (mem_ready) begin
                        if (m_ph == P_FETCH) m_ph = P_DECODE;
                        else done = 1;
                        m_stall = 0;
                    end else if (m_stall >= MWM) begin
                        m_ph = P_FAULT;
                    end else begin
                        m_stall++;
                    end
                end
                P_DECODE: m_ph = P_EXEC;
                P_EXEC: begin
                    if (nclass > 1) m_ph = P_FAULT;
                    else if (dec_load || dec_store) begin
                        m_ph = P_MEM; m_stall = 0;
                    end else done = 1;
                end
                P_HALT: if (!halt) begin
                    m_ph = P_FETCH; m_stall = 0;
                end
                default: m_ph = P_FAULT;
            endcase
            if (done) begin
                m_ret = (m_ret + 1) % (1 << CNT_W);
                m_stall = 0;
                m_ph = halt ? P_HALT : P_FETCH;
            end
        end
    endtask

    // Model update on each rising edge; full comparison on each falling edge.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            n_checks++;
            if (dut_vec() !== model_vec()) begin
                n_errors++;
                $display("FAIL outputs @%0t: got %b expected %b (IL,PCA,ALUA,RCS,RR,WRR,WR,SFL,INC,PCL,busy,fault)",
                         $time, dut_vec(), model_vec());
            end
            n_checks++;
            if (state !== (Reset ? 3'd0 : 3'(m_ph))) begin
                n_errors++;
                $display("FAIL state @%0t: got %0d expected %0d", $time, state, Reset ? 0 : m_ph);
            end
            n_checks++;
            if (retired !== CNT_W'(m_ret)) begin
                n_errors++;
                $display("FAIL retired @%0t: got %0d expected %0d", $time, retired, m_ret);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1; dec_WR = 0; dec_SFL = 0; dec_load = 0; dec_store = 0;
        dec_branch = 0; mem_ready = 0; halt = 0;
        tick(1);
        #1;
        lit("reset_state", 32'(state), 0);
        lit("reset_busy", 32'(busy), 0);
        lit("reset_rr", 32'(RR), 0);
        tick(1);

        // ADD: 3 cycles, WR only in EXECUTE.
        Reset = 0; mem_ready = 1; dec_WR = 1;
        #1;
        lit("add_c0_state", 32'(state), 0);
        lit("add_c0_il", 32'(IL), 1);
        lit("add_c0_pcinc", 32'(PC_INC), 1);
        lit("add_c0_wr", 32'(WR), 0);
        tick(1); #1;
        lit("add_c1_state", 32'(state), 1);
        tick(1); #1;
        lit("add_c2_state", 32'(state), 2);
        lit("add_c2_wr", 32'(WR), 1);
        tick(1); #1;
        lit("add_c3_state", 32'(state), 0);
        lit("add_retired", 32'(retired), 1);

        // Load, RAM ready on the third MEM cycle.
        dec_WR = 0; dec_load = 1;
        tick(1); mem_ready = 0;
        tick(1); #1;
        lit("ld_exec_state", 32'(state), 2);
        tick(1); #1;
        lit("ld_mem1_rr", 32'(RR), 1);
        lit("ld_mem1_alu", 32'(EN_ADDR_ALU), 1);
        lit("ld_mem1_wr", 32'(WR), 0);
        lit("ld_mem1_wrr", 32'(WRR), 0);
        tick(1);
        tick(1); mem_ready = 1; #1;
        lit("ld_mem3_state", 32'(state), 3);
        lit("ld_mem3_wr", 32'(WR), 1);
        tick(1); #1;
        lit("ld_retired", 32'(retired), 2);

        // Store with RAM stalled: fault after 16 MEM cycles.
        dec_load = 0; dec_store = 1;
        tick(1); mem_ready = 0;
        tick(1);
        tick(1); #1;
        lit("st_mem_wrr", 32'(WRR), 1);
        lit("st_mem_rr", 32'(RR), 0);
        tick(15); #1;
        lit("st_mem16_state", 32'(state), 3);
        tick(1); #1;
        lit("st_fault_state", 32'(state), 5);
        lit("st_fault_flag", 32'(fault), 1);
        lit("st_fault_busy", 32'(busy), 0);
        lit("st_fault_wrr", 32'(WRR), 0);
        halt = 1;
        tick(2); #1;
        lit("fault_sticky", 32'(state), 5);
        Reset = 1; halt = 0; dec_store = 0;
        tick(1); #1;
        lit("fault_clear", 32'(fault), 0);
        Reset = 0;
        #1;
        lit("after_reset_state", 32'(state), 0);

        // Branch with halt raised in DECODE.
        mem_ready = 1; dec_branch = 1;
        tick(1); halt = 1;
        tick(1); #1;
        lit("br_pcload", 32'(PC_LOAD), 1);
        tick(1); #1;
        lit("br_halted", 32'(state), 4);
        lit("br_pcload_off", 32'(PC_LOAD), 0);
        lit("br_halted_busy", 32'(busy), 0);
        tick(1); #1;
        lit("br_halt_hold", 32'(state), 4);
        halt = 0; dec_branch = 0;
        tick(1); #1;
        lit("br_resume", 32'(state), 0);

        // Conflicting class flags in EXECUTE.
        dec_branch = 1; dec_load = 1; dec_WR = 1; dec_SFL = 1;
        tick(2); #1;
        lit("multi_pcload", 32'(PC_LOAD), 0);
        lit("multi_wr", 32'(WR), 0);
        lit("multi_sfl", 32'(SFL), 0);
        tick(1); #1;
        lit("multi_fault", 32'(state), 5);
        Reset = 1; dec_branch = 0; dec_load = 0; dec_WR = 0; dec_SFL = 0;
        tick(1);
        Reset = 0;

        // Sixteen ALU ops: the 4-bit retired count wraps 15 -> 0.
        for (int i = 0; i < 15; i++) begin
            dec_SFL = i[0]; dec_WR = ~i[0];
            tick(3);
        end
        #1;
        lit("wrap_pre", 32'(retired), 15);
        tick(3); #1;
        lit("wrap_post", 32'(retired), 0);
        dec_SFL = 0; dec_WR = 0;

        // Fetch timeout.
        mem_ready = 0;
        tick(15); #1;
        lit("fetch_wait_state", 32'(state), 0);
        tick(1); #1;
        lit("fetch_fault", 32'(state), 5);
        Reset = 1;
        tick(1);
        Reset = 0; mem_ready = 1;

        // Reset arriving while a load is in MEM.
        dec_load = 1;
        tick(1); mem_ready = 0;
        tick(2); #1;
        lit("rst_mem_state", 32'(state), 3);
        mem_ready = 1; Reset = 1; #1;
        lit("rst_mem_wr", 32'(WR), 0);
        lit("rst_mem_rr", 32'(RR), 0);
        tick(1); #1;
        lit("rst_mem_ret", 32'(retired), 0);
        Reset = 0; dec_load = 0;
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
